// File: rtl/numberle_pkg.sv
// numberle_pkg: shared definitions for the Numberle datapath.
//   - keypad key-code constants (edit '*', enter '#') and the digit range limit
//   - guess-entry FSM state encoding
//   - number of digits per guess
//   - is_digit(): classifies a decoded key code as a numeric digit
package numberle_pkg;

  localparam logic [3:0] KEY_EDIT     = 4'hE;
  localparam logic [3:0] KEY_ENTER    = 4'hF;
  localparam logic [3:0] DIGIT_MAX    = 4'h9;
  localparam logic [2:0] GUESS_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } state_t;

  // True for key codes 0..9.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/guess_entry_buf.sv
// guess_entry_buf: four-digit entry shift register with digit count.
// Ports:
//   clock   in  1   system clock, rising edge
//   resetn  in  1   asynchronous active-low reset
//   push    in  1   shift 'digit' in at the low end (ignored when full)
//   pop     in  1   drop the most recently entered digit (ignored when empty)
//   flush   in  1   clear all digits; wins over pop and push
//   digit   in  4   digit to push
//   guess   out 16  entered digits, oldest in the highest nibble once full
//   count   out 3   number of digits held, 0..4
module guess_entry_buf
  import numberle_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [3:0]  digit,
  output logic [15:0] guess,
  output logic [2:0]  count
);

  logic [15:0] guess_r;
  logic [2:0]  count_r;

  // Digit shift register and occupancy count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      guess_r <= 16'h0000;
      count_r <= 3'd0;
    end else if (flush) begin
      guess_r <= 16'h0000;
      count_r <= 3'd0;
    end else if (pop && (count_r != 3'd0)) begin
      // Newest digit sits in the low nibble, so backspace shifts right.
      guess_r <= {4'h0, guess_r[15:4]};
      count_r <= count_r - 3'd1;
    end else if (push && (count_r < GUESS_DIGITS)) begin
      guess_r <= {guess_r[11:0], digit};
      count_r <= count_r + 3'd1;
    end else begin
      guess_r <= guess_r;
      count_r <= count_r;
    end
  end

  assign guess = guess_r;
  assign count = count_r;

endmodule

// File: rtl/guess_entry.sv
// guess_entry: keypad-side front end of the Numberle datapath.
// Collects digit keys into a four-digit guess, handles '*' (edit) and '#'
// (enter), hands the completed guess to the comparator over a valid/ack
// handshake and keeps the shared 'try' counter (odd while a guess is
// pending, even while typing).
// Build option:
//   GUESS_ENTRY_BACKSPACE_EN defined   -> '*' removes the newest digit
//   GUESS_ENTRY_BACKSPACE_EN undefined -> '*' clears the whole entry
// Parameter:
//   MAX_TRIES   guesses per game, 1..7
// Ports:
//   clock        in  1   system clock, rising edge
//   resetn       in  1   asynchronous active-low reset
//   key_valid    in  1   key_code valid this cycle
//   key_code     in  4   0..9 digit, E edit, F enter, A..D ignored
//   guess_ack    in  1   comparator consumed guess
//   solved       in  1   comparator result, used only with guess_ack
//   guess        out 16  entered digits
//   count        out 3   digits entered, 0..4
//   guess_valid  out 1   guess submitted, held until acked
//   try          out 4   2 * completed guesses, +1 while pending
//   done         out 1   game over
module guess_entry
  import numberle_pkg::*;
#(
  parameter int MAX_TRIES = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        guess_ack,
  input  logic        solved,
  output logic [15:0] guess,
  output logic [2:0]  count,
  output logic        guess_valid,
  output logic [3:0]  try,
  output logic        done
);

  // try value reached after the final guess of a game has been acked.
  localparam logic [3:0] TRY_LIMIT = 4'(2 * MAX_TRIES);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  try_r;
  logic [3:0]  try_nxt_s;
  logic [3:0]  try_inc_s;
  logic        guess_valid_r;
  logic        guess_valid_nxt_s;
  logic        done_r;
  logic        done_nxt_s;
  logic        push_s;
  logic        pop_s;
  logic        flush_s;
  logic [15:0] guess_s;
  logic [2:0]  count_s;

  assign try_inc_s = try_r + 4'd1;

  guess_entry_buf u_buf (
    .clock  (clock),
    .resetn (resetn),
    .push   (push_s),
    .pop    (pop_s),
    .flush  (flush_s),
    .digit  (key_code),
    .guess  (guess_s),
    .count  (count_s)
  );

  // Next-state, buffer controls and next output values.
  always_comb begin
    state_nxt_s       = state_r;
    try_nxt_s         = try_r;
    guess_valid_nxt_s = guess_valid_r;
    done_nxt_s        = done_r;
    push_s            = 1'b0;
    pop_s             = 1'b0;
    flush_s           = 1'b0;

    case (state_r)
      ENTRY: begin
        guess_valid_nxt_s = 1'b0;
        done_nxt_s        = 1'b0;
        if (key_valid) begin
          if (is_digit(key_code)) begin
            // The buffer itself ignores pushes once four digits are held.
            push_s = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            if (count_s == GUESS_DIGITS) begin
              state_nxt_s       = PENDING;
              guess_valid_nxt_s = 1'b1;
              try_nxt_s         = try_inc_s;
            end else begin
              state_nxt_s = ENTRY;
            end
          end else if (key_code == KEY_EDIT) begin
`ifdef GUESS_ENTRY_BACKSPACE_EN
            pop_s   = 1'b1;
`else
            flush_s = 1'b1;
`endif
          end else begin
            state_nxt_s = ENTRY;
          end
        end else begin
          state_nxt_s = ENTRY;
        end
      end

      PENDING: begin
        // Keys are dropped here; only the ack moves the FSM on.
        if (guess_ack) begin
          guess_valid_nxt_s = 1'b0;
          flush_s           = 1'b1;
          try_nxt_s         = try_inc_s;
          if (solved || (try_inc_s == TRY_LIMIT)) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ENTRY;
          end
        end else begin
          state_nxt_s = PENDING;
        end
      end

      DONE: begin
        state_nxt_s       = DONE;
        guess_valid_nxt_s = 1'b0;
        done_nxt_s        = 1'b1;
      end

      default: begin
        // Unreachable encoding: fall back to a clean entry state.
        state_nxt_s       = ENTRY;
        guess_valid_nxt_s = 1'b0;
        done_nxt_s        = 1'b0;
        flush_s           = 1'b1;
        try_nxt_s         = 4'd0;
      end
    endcase
  end

  // FSM state, try counter and handshake/status output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ENTRY;
      try_r         <= 4'd0;
      guess_valid_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      try_r         <= try_nxt_s;
      guess_valid_r <= guess_valid_nxt_s;
      done_r        <= done_nxt_s;
    end
  end

  assign guess       = guess_s;
  assign count       = count_s;
  assign guess_valid = guess_valid_r;
  assign try         = try_r;
  assign done        = done_r;

endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: self-checking bench for guess_entry.
// A reference model predicts the outputs after every driven cycle; the
// prediction is queued and compared one edge later. Fixed-value checks
// from the game scenarios go through the same check task.
// Honors GUESS_ENTRY_BACKSPACE_EN the same way as the design.
module tb_guess_entry;

  localparam int MAX_TRIES = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        guess_ack;
  logic        solved;
  logic [15:0] guess;
  logic [2:0]  count;
  logic        guess_valid;
  logic [3:0]  try;
  logic        done;

  typedef struct packed {
    logic [15:0] g;
    logic [2:0]  c;
    logic        v;
    logic [3:0]  t;
    logic        d;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state: 0 typing, 1 pending, 2 game over
  int          m_state;
  logic [15:0] m_guess;
  int          m_count;
  logic        m_valid;
  int          m_try;
  logic        m_done;

  guess_entry #(.MAX_TRIES(MAX_TRIES)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .guess_ack   (guess_ack),
    .solved      (solved),
    .guess       (guess),
    .count       (count),
    .guess_valid (guess_valid),
    .try         (try),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_guess = 16'h0000;
    m_count = 0;
    m_valid = 1'b0;
    m_try   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] code, input logic ack, input logic sol);
    if (m_state == 0) begin
      if (kv) begin
        if (code <= 4'h9) begin
          if (m_count < 4) begin
            m_guess = {m_guess[11:0], code};
            m_count = m_count + 1;
          end
        end else if (code == 4'hF) begin
          if (m_count == 4) begin
            m_state = 1;
            m_valid = 1'b1;
            m_try   = m_try + 1;
          end
        end else if (code == 4'hE) begin
`ifdef GUESS_ENTRY_BACKSPACE_EN
          if (m_count > 0) begin
            m_guess = m_guess >> 4;
            m_count = m_count - 1;
          end
`else
          m_guess = 16'h0000;
          m_count = 0;
`endif
        end
      end
    end else if (m_state == 1) begin
      if (ack) begin
        m_valid = 1'b0;
        m_guess = 16'h0000;
        m_count = 0;
        m_try   = m_try + 1;
        if (sol || (m_try == 2 * MAX_TRIES)) begin
          m_state = 2;
          m_done  = 1'b1;
        end else begin
          m_state = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, predict its outcome, and release the inputs.
  task automatic cyc(input logic kv, input logic [3:0] code, input logic ack, input logic sol);
    exp_t e;
    @(negedge clock);
    key_valid = kv;
    key_code  = code;
    guess_ack = ack;
    solved    = sol;
    model_step(kv, code, ack, sol);
    e.g = m_guess;
    e.c = 3'(m_count);
    e.v = m_valid;
    e.t = 4'(m_try);
    e.d = m_done;
    sb_q.push_back(e);
    @(posedge clock);
    #2;
    key_valid = 1'b0;
    guess_ack = 1'b0;
    solved    = 1'b0;
  endtask

  task automatic key(input logic [3:0] code);
    cyc(1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_guess"}, 32'(guess), 32'h0);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_valid"}, 32'(guess_valid), 32'h0);
    check({tag, "_try"},   32'(try), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #2;
    check_zero("rst");
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Scoreboard: compare the oldest prediction just after each active edge.
  always @(posedge clock) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      check("sb_guess", 32'(guess), 32'(sb_e.g));
      check("sb_count", 32'(count), 32'(sb_e.c));
      check("sb_valid", 32'(guess_valid), 32'(sb_e.v));
      check("sb_try",   32'(try), 32'(sb_e.t));
      check("sb_done",  32'(done), 32'(sb_e.d));
    end
  end

  initial begin
    resetn    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    guess_ack = 1'b0;
    solved    = 1'b0;
    model_reset();
    #12;
    check_zero("init");
    @(negedge clock);
    resetn = 1'b1;

    // First guess 1234, submit, keys dropped while pending, ack unsolved.
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    check("tp1_guess", 32'(guess), 32'h1234);
    check("tp1_count", 32'(count), 32'd4);
    key(4'hF);
    check("tp1_valid", 32'(guess_valid), 32'd1);
    check("tp1_try",   32'(try), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    key(4'h5);
    check("tp1_pend_guess", 32'(guess), 32'h1234);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("tp1_ack_valid", 32'(guess_valid), 32'd0);
    check("tp1_ack_guess", 32'(guess), 32'h0);
    check("tp1_ack_try",   32'(try), 32'd2);

    // Short enter ignored, ignored codes, fifth digit ignored.
    key(4'h5); key(4'h6); key(4'hF);
    check("tp2_short_valid", 32'(guess_valid), 32'd0);
    key(4'hA); key(4'hD);
    key(4'h7); key(4'h8); key(4'h9); key(4'h0); key(4'h1);
    check("tp2_guess", 32'(guess), 32'h5678);
    check("tp2_count", 32'(count), 32'd4);
    key(4'hF);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("tp2_try", 32'(try), 32'd4);

    // Edit key behaviour, then fill up to four digits.
    key(4'h1); key(4'h2); key(4'h3); key(4'hE); key(4'h4); key(4'h5);
`ifdef GUESS_ENTRY_BACKSPACE_EN
    check("tp3_bs_guess", 32'(guess), 32'h1245);
    check("tp3_bs_count", 32'(count), 32'd4);
`else
    check("tp3_clr_guess", 32'(guess), 32'h0045);
    check("tp3_clr_count", 32'(count), 32'd2);
    key(4'h6); key(4'h7);
`endif
    // Ack outside PENDING is ignored.
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    check("tp3_stray_ack_done", 32'(done), 32'd0);
    key(4'hF);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("tp3_try", 32'(try), 32'd6);

    // Fourth guess exhausts the tries.
    key(4'h1); key(4'h1); key(4'h1); key(4'h1); key(4'hF);
    check("tp4_try_pend", 32'(try), 32'd7);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("tp4_try",  32'(try), 32'd8);
    check("tp4_done", 32'(done), 32'd1);
    key(4'h9); key(4'hE); key(4'h3); key(4'hF);
    check("tp4_after_guess", 32'(guess), 32'h0);
    check("tp4_after_try",   32'(try), 32'd8);

    // Solved on the second guess; key in the ack cycle is dropped.
    do_reset();
    key(4'h2); key(4'h4); key(4'h6); key(4'h8); key(4'hF);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    key(4'h1); key(4'h3); key(4'h5); key(4'h7); key(4'hF);
    cyc(1'b1, 4'h9, 1'b1, 1'b1);
    check("tp5_try",   32'(try), 32'd4);
    check("tp5_done",  32'(done), 32'd1);
    check("tp5_count", 32'(count), 32'd0);
    check("tp5_guess", 32'(guess), 32'h0);

    // Asynchronous reset while a guess is pending at try 3.
    do_reset();
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hF);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    key(4'h4); key(4'h3); key(4'h2); key(4'h1); key(4'hF);
    check("tp6_pend_try",   32'(try), 32'd3);
    check("tp6_pend_valid", 32'(guess_valid), 32'd1);
    do_reset();
    key(4'h3);
    check("tp6_new_guess", 32'(guess), 32'h0003);
    check("tp6_new_count", 32'(count), 32'd1);
    check("tp6_new_try",   32'(try), 32'd0);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
